// File: rtl/id_stage_reg.sv
// ID/EXE pipeline register. Each cycle it takes exactly one action: flush to a bubble,
// freeze (hold), or load. It also keeps a saturating count of the bubbles it inserts.
module id_stage_reg #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_read_en_in,
    input  logic              mem_write_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic [WORD_W-1:0] pc_in,
    input  logic [WORD_W-1:0] val_rn_in,
    input  logic [WORD_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic              carry_in,
    output logic              valid_out,
    output logic              wb_en_out,
    output logic              mem_read_en_out,
    output logic              mem_write_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [3:0]        exe_cmd_out,
    output logic [WORD_W-1:0] pc_out,
    output logic [WORD_W-1:0] val_rn_out,
    output logic [WORD_W-1:0] val_rm_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic              carry_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_FREEZE,
        ACT_FLUSH
    } action_e;

    action_e action;

    logic              valid_q,         valid_d;
    logic              wb_en_q,         wb_en_d;
    logic              mem_read_en_q,   mem_read_en_d;
    logic              mem_write_en_q,  mem_write_en_d;
    logic              b_q,             b_d;
    logic              s_q,             s_d;
    logic [3:0]        exe_cmd_q,       exe_cmd_d;
    logic [WORD_W-1:0] pc_q,            pc_d;
    logic [WORD_W-1:0] val_rn_q,        val_rn_d;
    logic [WORD_W-1:0] val_rm_q,        val_rm_d;
    logic              imm_q,           imm_d;
    logic [11:0]       shift_operand_q, shift_operand_d;
    logic [23:0]       signed_imm24_q,  signed_imm24_d;
    logic [3:0]        dest_q,          dest_d;
    logic [3:0]        src1_q,          src1_d;
    logic [3:0]        src2_q,          src2_d;
    logic              carry_q,         carry_d;
    logic [CNT_W-1:0]  bubble_cnt_q,    bubble_cnt_d;
    logic              bubble_event;

    // Flush outranks freeze so a taken branch is never stalled behind a hazard.
    always_comb begin
        action = ACT_LOAD;
        if (flush) begin
            action = ACT_FLUSH;
        end else if (freeze) begin
            action = ACT_FREEZE;
        end
    end

    always_comb begin
        valid_d         = valid_q;
        wb_en_d         = wb_en_q;
        mem_read_en_d   = mem_read_en_q;
        mem_write_en_d  = mem_write_en_q;
        b_d             = b_q;
        s_d             = s_q;
        exe_cmd_d       = exe_cmd_q;
        pc_d            = pc_q;
        val_rn_d        = val_rn_q;
        val_rm_d        = val_rm_q;
        imm_d           = imm_q;
        shift_operand_d = shift_operand_q;
        signed_imm24_d  = signed_imm24_q;
        dest_d          = dest_q;
        src1_d          = src1_q;
        src2_d          = src2_q;
        carry_d         = carry_q;
        bubble_event    = 1'b0;

        unique case (action)
            ACT_FLUSH: begin
                valid_d        = 1'b0;
                wb_en_d        = 1'b0;
                mem_read_en_d  = 1'b0;
                mem_write_en_d = 1'b0;
                b_d            = 1'b0;
                s_d            = 1'b0;
                exe_cmd_d      = '0;
                bubble_event   = 1'b1;
            end
            ACT_LOAD: begin
                valid_d         = valid_in;
                wb_en_d         = valid_in & wb_en_in;
                mem_read_en_d   = valid_in & mem_read_en_in;
                // A read request wins a read/write conflict.
                mem_write_en_d  = valid_in & mem_write_en_in & ~mem_read_en_in;
                b_d             = valid_in & b_in;
                s_d             = valid_in & s_in;
                exe_cmd_d       = valid_in ? exe_cmd_in : '0;
                pc_d            = pc_in;
                val_rn_d        = val_rn_in;
                val_rm_d        = val_rm_in;
                imm_d           = imm_in;
                shift_operand_d = shift_operand_in;
                signed_imm24_d  = signed_imm24_in;
                dest_d          = dest_in;
                src1_d          = src1_in;
                src2_d          = src2_in;
                carry_d         = carry_in;
                bubble_event    = ~valid_in;
            end
            default: begin
            end
        endcase

        bubble_cnt_d = bubble_cnt_q;
        if (bubble_event && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q         <= 1'b0;
            wb_en_q         <= 1'b0;
            mem_read_en_q   <= 1'b0;
            mem_write_en_q  <= 1'b0;
            b_q             <= 1'b0;
            s_q             <= 1'b0;
            exe_cmd_q       <= '0;
            pc_q            <= '0;
            val_rn_q        <= '0;
            val_rm_q        <= '0;
            imm_q           <= 1'b0;
            shift_operand_q <= '0;
            signed_imm24_q  <= '0;
            dest_q          <= '0;
            src1_q          <= '0;
            src2_q          <= '0;
            carry_q         <= 1'b0;
            bubble_cnt_q    <= '0;
        end else begin
            valid_q         <= valid_d;
            wb_en_q         <= wb_en_d;
            mem_read_en_q   <= mem_read_en_d;
            mem_write_en_q  <= mem_write_en_d;
            b_q             <= b_d;
            s_q             <= s_d;
            exe_cmd_q       <= exe_cmd_d;
            pc_q            <= pc_d;
            val_rn_q        <= val_rn_d;
            val_rm_q        <= val_rm_d;
            imm_q           <= imm_d;
            shift_operand_q <= shift_operand_d;
            signed_imm24_q  <= signed_imm24_d;
            dest_q          <= dest_d;
            src1_q          <= src1_d;
            src2_q          <= src2_d;
            carry_q         <= carry_d;
            bubble_cnt_q    <= bubble_cnt_d;
        end
    end

    assign valid_out         = valid_q;
    assign wb_en_out         = wb_en_q;
    assign mem_read_en_out   = mem_read_en_q;
    assign mem_write_en_out  = mem_write_en_q;
    assign b_out             = b_q;
    assign s_out             = s_q;
    assign exe_cmd_out       = exe_cmd_q;
    assign pc_out            = pc_q;
    assign val_rn_out        = val_rn_q;
    assign val_rm_out        = val_rm_q;
    assign imm_out           = imm_q;
    assign shift_operand_out = shift_operand_q;
    assign signed_imm24_out  = signed_imm24_q;
    assign dest_out          = dest_q;
    assign src1_out          = src1_q;
    assign src2_out          = src2_q;
    assign carry_out         = carry_q;
    assign bubble_cnt        = bubble_cnt_q;

endmodule
